// File: rtl/rmii_rx_pkg.sv
// Shared types and constants for the RMII receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rmii_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_DROP
  } state_t;

  localparam logic [1:0]  PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0]  SFD_DIBIT      = 2'b11;
  localparam logic [31:0] CRC_POLY       = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT       = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE    = 32'hDEBB20E3;
  localparam int          FCS_BYTES      = 4;

endpackage

// File: rtl/eth_crc32_d8.sv
// One-byte update of the reflected Ethernet CRC-32 (bit 0 of the byte first).
// Latency: combinational.
// Backpressure: none.
// Ports: crc_i current register, data_i byte, crc_o updated register.
module eth_crc32_d8
  import rmii_rx_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  always_comb begin
    crc_o = crc_i;
    for (int i = 0; i < 8; i++) begin
      if (crc_o[0] ^ data_i[i]) crc_o = (crc_o >> 1) ^ CRC_POLY;
      else                      crc_o = crc_o >> 1;
    end
  end

endmodule

// File: rtl/rmii_frame_rx.sv
// RMII receive front end: preamble/SFD strip, byte assembly, FCS check and strip, AXIS byte out.
// Latency: tlast beat valid 3 clocks after the last FCS dibit is sampled (tready high).
// Backpressure: one holding register; payload bytes arriving while it is full are lost
//   (rx_overflow, frame marked bad); the tlast byte is held back until the register frees.
// Ports: m00_axis_aclk/aresetn clock and async reset; ETH_CRSDV/ETH_RXD/ETH_RXERR RMII pins;
//   m00_axis_t* AXIS byte master; rx_good/rx_bad/rx_overflow single-cycle status pulses.
module rmii_frame_rx
  import rmii_rx_pkg::*;
#(
  parameter int MIN_PREAMBLE_DIBITS = 8,
  parameter int MIN_FRAME_BYTES     = 64,
  parameter int MAX_FRAME_BYTES     = 1518
) (
  input  logic       m00_axis_aclk,
  input  logic       m00_axis_aresetn,
  input  logic       ETH_CRSDV,
  input  logic       ETH_RXERR,
  input  logic [1:0] ETH_RXD,
  output logic       m00_axis_tvalid,
  output logic [7:0] m00_axis_tdata,
  output logic       m00_axis_tlast,
  output logic       m00_axis_tuser,
  input  logic       m00_axis_tready,
  output logic       rx_good,
  output logic       rx_bad,
  output logic       rx_overflow
);

  localparam int          DL_DEPTH = FCS_BYTES + 1;
  localparam logic [2:0]  DL_FULL  = 3'(DL_DEPTH);
  localparam logic [7:0]  MIN_PRE  = 8'(MIN_PREAMBLE_DIBITS);
  localparam logic [15:0] MIN_B    = 16'(MIN_FRAME_BYTES);
  localparam logic [15:0] MAX_B    = 16'(MAX_FRAME_BYTES);

  // Two pin stages: s2 is the dibit being decided on, s1 is one cycle of lookahead
  // so a lone CRSDV=0 cycle can be told apart from the end of the frame.
  logic       s1_crs_q, s1_err_q, s2_crs_q, s2_err_q;
  logic [1:0] s1_rxd_q, s2_rxd_q;

  state_t      state_q;
  logic [7:0]  pre_cnt_q;
  logic [7:0]  sr_q;
  logic [1:0]  dibit_cnt_q;
  logic [31:0] crc_q;
  logic [15:0] byte_cnt_q;
  logic [7:0]  dl_q [DL_DEPTH];   // dl_q[DL_DEPTH-1] is the oldest byte
  logic [2:0]  dl_cnt_q;
  logic        bad_q;
  logic        pend_q, pend_user_q;
  logic        out_vld_q, out_last_q, out_user_q;
  logic [7:0]  out_dat_q;
  logic        bad_pulse_q, ovf_pulse_q;

  logic        dibit_take, frame_end, byte_done, oversize, emit_byte;
  logic        end_tlast, end_verdict, tlast_req, tlast_user, out_free, hs;
  logic [7:0]  byte_new;
  logic [31:0] crc_next;

  eth_crc32_d8 u_crc (
    .crc_i  (crc_q),
    .data_i (byte_new),
    .crc_o  (crc_next)
  );

  assign dibit_take  = (state_q == ST_DATA) && (s2_crs_q || s1_crs_q);
  assign frame_end   = (state_q == ST_DATA) && !s2_crs_q && !s1_crs_q;
  assign byte_new    = {s2_rxd_q, sr_q[7:2]};
  assign byte_done   = dibit_take && (dibit_cnt_q == 2'd3);
  assign oversize    = byte_done && (byte_cnt_q == MAX_B);
  assign emit_byte   = byte_done && !oversize && (dl_cnt_q == DL_FULL);
  assign end_tlast   = frame_end && (dl_cnt_q == DL_FULL);
  assign end_verdict = bad_q || s2_err_q || (crc_q != CRC_RESIDUE) ||
                       (byte_cnt_q < MIN_B) || (dibit_cnt_q != 2'd0);
  assign tlast_req   = pend_q || end_tlast || oversize;
  assign tlast_user  = pend_q ? pend_user_q : (oversize || end_verdict);
  assign out_free    = !out_vld_q || m00_axis_tready;
  assign hs          = out_vld_q && m00_axis_tready;

  assign m00_axis_tvalid = out_vld_q;
  assign m00_axis_tdata  = out_dat_q;
  assign m00_axis_tlast  = out_last_q;
  assign m00_axis_tuser  = out_user_q;
  assign rx_good         = hs && out_last_q && !out_user_q;
  assign rx_bad          = (hs && out_last_q && out_user_q) || bad_pulse_q;
  assign rx_overflow     = ovf_pulse_q;

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      s1_crs_q    <= 1'b0;
      s1_err_q    <= 1'b0;
      s1_rxd_q    <= 2'b00;
      s2_crs_q    <= 1'b0;
      s2_err_q    <= 1'b0;
      s2_rxd_q    <= 2'b00;
      state_q     <= ST_IDLE;
      pre_cnt_q   <= 8'd0;
      sr_q        <= 8'd0;
      dibit_cnt_q <= 2'd0;
      crc_q       <= CRC_INIT;
      byte_cnt_q  <= 16'd0;
      for (int i = 0; i < DL_DEPTH; i++) dl_q[i] <= 8'd0;
      dl_cnt_q    <= 3'd0;
      bad_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_user_q <= 1'b0;
      out_vld_q   <= 1'b0;
      out_dat_q   <= 8'd0;
      out_last_q  <= 1'b0;
      out_user_q  <= 1'b0;
      bad_pulse_q <= 1'b0;
      ovf_pulse_q <= 1'b0;
    end else begin
      s1_crs_q    <= ETH_CRSDV;
      s1_err_q    <= ETH_RXERR;
      s1_rxd_q    <= ETH_RXD;
      s2_crs_q    <= s1_crs_q;
      s2_err_q    <= s1_err_q;
      s2_rxd_q    <= s1_rxd_q;
      bad_pulse_q <= 1'b0;
      ovf_pulse_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (s2_crs_q) begin
            if (s2_rxd_q == PREAMBLE_DIBIT) begin
              state_q   <= ST_PREAMBLE;
              pre_cnt_q <= 8'd1;
            end else begin
              state_q     <= ST_DROP;
              bad_pulse_q <= 1'b1;
            end
          end
        end

        ST_PREAMBLE: begin
          if (!s2_crs_q) begin
            state_q <= ST_IDLE;
          end else if (s2_rxd_q == PREAMBLE_DIBIT) begin
            if (pre_cnt_q != 8'hFF) pre_cnt_q <= pre_cnt_q + 8'd1;
          end else if ((s2_rxd_q == SFD_DIBIT) && (pre_cnt_q >= MIN_PRE)) begin
            if (pend_q) begin
              // Previous frame's tlast still owns the delay line.
              state_q     <= ST_DROP;
              bad_pulse_q <= 1'b1;
              ovf_pulse_q <= 1'b1;
            end else begin
              state_q     <= ST_DATA;
              dibit_cnt_q <= 2'd0;
              crc_q       <= CRC_INIT;
              byte_cnt_q  <= 16'd0;
              dl_cnt_q    <= 3'd0;
              bad_q       <= 1'b0;
            end
          end else begin
            state_q     <= ST_DROP;
            bad_pulse_q <= 1'b1;
          end
        end

        ST_DATA: begin
          if (s2_err_q) bad_q <= 1'b1;
          if (frame_end) begin
            state_q <= ST_IDLE;
            // Too short to hold a payload byte plus FCS: nothing to emit.
            if (!end_tlast) bad_pulse_q <= 1'b1;
          end else if (dibit_take) begin
            sr_q        <= byte_new;
            dibit_cnt_q <= dibit_cnt_q + 2'd1;
            if (byte_done) begin
              crc_q      <= crc_next;
              byte_cnt_q <= byte_cnt_q + 16'd1;
              if (oversize) begin
                // Oldest byte leaves as a bad tlast; rx_bad comes with its transfer.
                state_q <= ST_DROP;
              end else begin
                dl_q[0] <= byte_new;
                for (int i = 1; i < DL_DEPTH; i++) dl_q[i] <= dl_q[i-1];
                if (dl_cnt_q != DL_FULL) dl_cnt_q <= dl_cnt_q + 3'd1;
                if (emit_byte && !out_free) begin
                  ovf_pulse_q <= 1'b1;
                  bad_q       <= 1'b1;
                end
              end
            end
          end
        end

        ST_DROP: begin
          if (!s2_crs_q && !s1_crs_q) state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase

      // Output holding register; the tlast byte always comes from the oldest
      // delay-line entry, which stays frozen while it is pending.
      if (out_free) begin
        if (tlast_req) begin
          out_vld_q  <= 1'b1;
          out_dat_q  <= dl_q[DL_DEPTH-1];
          out_last_q <= 1'b1;
          out_user_q <= tlast_user;
          pend_q     <= 1'b0;
        end else if (emit_byte) begin
          out_vld_q  <= 1'b1;
          out_dat_q  <= dl_q[DL_DEPTH-1];
          out_last_q <= 1'b0;
          out_user_q <= 1'b0;
        end else begin
          out_vld_q  <= 1'b0;
        end
      end else if (tlast_req) begin
        pend_q      <= 1'b1;
        pend_user_q <= tlast_user;
      end
    end
  end

endmodule

// File: doc/rmii_frame_rx.md
Name: rmii_frame_rx

Overview:
- RMII receive MAC front end: samples the PHY dibit stream (ETH_CRSDV/ETH_RXD/ETH_RXERR) and strips preamble/SFD.
- Assembles bytes LSB-first, checks the CRC-32 FCS and frame length, and streams frame bytes (FCS removed) out on an AXI4-Stream byte master.
- tlast marks the final payload byte; tuser carries the frame-bad verdict. Sits between the RMII pins and the UDP/IP packet receiver, as the receive counterpart to the packet generator's dibit serializer.

Parameters:
- MIN_PREAMBLE_DIBITS, 8, minimum count of consecutive 01 dibits before SFD is accepted.
- MIN_FRAME_BYTES, 64, minimum frame length (DA through FCS); shorter frames are flagged bad.
- MAX_FRAME_BYTES, 1518, maximum frame length; longer frames are truncated and flagged bad.

Ports:
- m00_axis_aclk  in  1  50 MHz RMII reference clock; one dibit per cycle.
- m00_axis_aresetn  in  1  asynchronous active-low reset.
- ETH_CRSDV  in  1  RMII carrier sense / data valid.
- ETH_RXERR  in  1  PHY receive error.
- ETH_RXD  in  2  receive dibit.
- m00_axis_tvalid  out  1  output byte valid.
- m00_axis_tdata  out  8  output byte.
- m00_axis_tlast  out  1  last payload byte of frame.
- m00_axis_tuser  out  1  valid with tlast; 1 = frame bad (FCS, RXERR, runt, oversize, overflow).
- m00_axis_tready  in  1  downstream ready.
- rx_good  out  1  one-cycle pulse when a good frame's tlast is accepted.
- rx_bad  out  1  one-cycle pulse when a bad frame's tlast is accepted, or when a frame is dropped.
- rx_overflow  out  1  one-cycle pulse on any data loss due to backpressure.

Behaviour:
- Reset (async, aresetn=0): all outputs 0, state IDLE, delay line and counters cleared, CRC reg = 0xFFFFFFFF. Reset mid-frame discards the frame with no tlast.
- States: IDLE, PREAMBLE, DATA, DROP.
- IDLE: CRSDV=1 and RXD=01 -> PREAMBLE, preamble count = 1. CRSDV=1 with any other RXD -> DROP.
- PREAMBLE:
  - RXD=01 increments the count (saturating).
  - RXD=11 with count >= MIN_PREAMBLE_DIBITS -> DATA.
  - RXD=11 with count too low, or RXD=00/10 -> DROP.
  - CRSDV=0 -> IDLE, silently.
- DATA:
  - Dibits collected LSB-first; byte = {d3,d2,d1,d0}.
  - A single cycle with CRSDV=0 followed by CRSDV=1 (end-of-frame toggling) is a valid dibit.
  - Two consecutive CRSDV=0 cycles end the frame; both dibits are discarded.
  - ETH_RXERR=1 on any DATA cycle sets the bad flag.
- DROP: wait for CRSDV=0 for two consecutive cycles -> IDLE; pulse rx_bad once on entry (not on the PREAMBLE->IDLE abort path).
- CRC: reflected CRC-32, poly 0xEDB88320, init 0xFFFFFFFF, updated on every completed byte including FCS. At frame end the register must equal residue 0xDEBB20E3, else bad.
- FCS stripping: completed bytes enter a 5-byte delay line; the byte shifted out is emitted with tlast=0.
  - At frame end, the oldest entry is the last payload byte: emit it with tlast=1 and tuser=bad. The remaining 4 entries (FCS) are discarded.
  - Frames with fewer than 5 bytes emit nothing, pulse rx_bad, return to IDLE.
  - Dibit count not a multiple of 4 at frame end -> bad.
- Length: byte count < MIN_FRAME_BYTES -> bad. On reaching MAX_FRAME_BYTES+1, emit the current oldest byte with tlast=1, tuser=1, then -> DROP. rx_bad pulses once for the frame.
- Output register:
  - Single holding register, standard AXIS: tdata/tlast/tuser stable while tvalid && !tready.
  - A byte due to be emitted while the register is full is dropped: pulse rx_overflow, set bad.
  - A pending tlast byte is never dropped; it waits in the delay line until the register frees.
  - An SFD arriving while the previous tlast is still pending -> DROP, rx_overflow pulse.
- Latency: tlast byte tvalid rises 3 cycles after the last FCS dibit cycle, with tready held 1.
- rx_good/rx_bad pulse in the cycle the tlast transfer completes (tvalid && tready), except the drop cases above.

Decomposition:
- Package rmii_rx_pkg: state enum; PREAMBLE_DIBIT 2'b01; SFD_DIBIT 2'b11; CRC_POLY 32'hEDB88320; CRC_INIT 32'hFFFFFFFF; CRC_RESIDUE 32'hDEBB20E3; FCS_BYTES 4.
- Sub-module eth_crc32_d8: combinational one-byte reflected CRC-32 update (crc_in, byte -> crc_out), reusable by the transmitter.

Test Plan:
- Good frame: 15 dibits 01 + SFD 11, then 60 payload bytes 0x00..0x3B plus correct FCS, tready=1 -> 60 beats 0x00..0x3B; tlast on 0x3B, tuser=0, rx_good=1 once.
- FCS error: same frame with FCS byte 0 XOR 0x01 -> 60 beats, tlast tuser=1, rx_bad=1, rx_good=0.
- RXERR: ETH_RXERR=1 for one cycle mid-payload -> 60 beats, tuser=1 on tlast. Runt of 20 bytes with valid FCS -> 16 beats, tuser=1.
- Backpressure: tready=0 for 12 cycles mid-frame -> rx_overflow pulses, some bytes lost, tlast still delivered with tuser=1, tdata stable while stalled.
- End toggling: CRSDV pattern 1,0,1,0,0 over the last FCS dibits -> frame decoded correctly, tuser=0. Preamble of 4 dibits then SFD -> DROP, no output, rx_bad=1.
- Reset: aresetn low for 1 cycle at byte 30 -> all outputs 0 immediately, no tlast; next good frame decodes cleanly.
